// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic {IDLE, RD_WAIT} state_t;
   typedef enum logic {OWN_CORE, OWN_DBG} owner_t;

   localparam int LAT_W = 3;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin picker; req[0]=core, req[1]=debug
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  owner_t     last,
   output logic [1:0] grant,
   output owner_t     winner
);

   always_comb begin
      grant  = 2'b00;
      winner = OWN_CORE;
      case (req)
         2'b01: begin
            grant  = 2'b01;
            winner = OWN_CORE;
         end
         2'b10: begin
            grant  = 2'b10;
            winner = OWN_DBG;
         end
         2'b11: begin
            // On a tie the requester that did not win last time goes first
            if (last == OWN_CORE) begin
               grant  = 2'b10;
               winner = OWN_DBG;
            end else begin
               grant  = 2'b01;
               winner = OWN_CORE;
            end
         end
         default: begin
            grant  = 2'b00;
            winner = OWN_CORE;
         end
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous-read memory port between core and debug loader
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int AW           = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [31:0]   core_wdata,
   input  logic [2:0]    core_funct3,
   output logic          core_gnt,
   output logic          core_rvalid,
   output logic [31:0]   core_rdata,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [31:0]   dbg_wdata,
   input  logic [2:0]    dbg_funct3,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [31:0]   dbg_rdata,
   input  logic          dbg_lock,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [2:0]    mem_funct3,
   input  logic [31:0]   mem_rdata,
   output logic          busy
);

   state_t             r_state;
   owner_t             r_owner;
   owner_t             r_last;
   logic [LAT_W-1:0]   r_lat;
   logic [AW-1:0]      r_addr;
   logic [31:0]        r_wdata;
   logic [2:0]         r_funct3;
   logic [31:0]        r_core_rdata;
   logic [31:0]        r_dbg_rdata;

   logic [1:0]         w_req;
   logic [1:0]         w_grant;
   owner_t             w_winner;
   logic               w_any;
   logic               w_sel_we;
   logic [AW-1:0]      w_sel_addr;
   logic [31:0]        w_sel_wdata;
   logic [2:0]         w_sel_funct3;
   logic               w_done;

   // Grants are combinational, so they are masked while reset is held low
   assign w_req = {dbg_req, core_req & ~dbg_lock} & {2{(r_state == IDLE) & reset}};

   rr_pick2 u_pick (
      .req    (w_req),
      .last   (r_last),
      .grant  (w_grant),
      .winner (w_winner)
   );

   assign w_any        = |w_grant;
   assign w_sel_we     = w_grant[1] ? dbg_we     : core_we;
   assign w_sel_addr   = w_grant[1] ? dbg_addr   : core_addr;
   assign w_sel_wdata  = w_grant[1] ? dbg_wdata  : core_wdata;
   assign w_sel_funct3 = w_grant[1] ? dbg_funct3 : core_funct3;
   assign w_done       = (r_state == RD_WAIT) && (r_lat == '0);

   assign core_gnt   = w_grant[0];
   assign dbg_gnt    = w_grant[1];
   assign mem_we     = w_any & w_sel_we;
   assign mem_addr   = w_any ? w_sel_addr   : r_addr;
   assign mem_wdata  = w_any ? w_sel_wdata  : r_wdata;
   assign mem_funct3 = w_any ? w_sel_funct3 : r_funct3;
   assign busy       = (r_state == RD_WAIT);

   // Read data passes straight through on the rvalid cycle, then holds the captured copy
   assign core_rvalid = w_done && (r_owner == OWN_CORE);
   assign dbg_rvalid  = w_done && (r_owner == OWN_DBG);
   assign core_rdata  = core_rvalid ? mem_rdata : r_core_rdata;
   assign dbg_rdata   = dbg_rvalid  ? mem_rdata : r_dbg_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_owner      <= OWN_CORE;
         r_last       <= OWN_DBG;
         r_lat        <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_funct3     <= '0;
         r_core_rdata <= '0;
         r_dbg_rdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_last   <= w_winner;
                  r_addr   <= w_sel_addr;
                  r_wdata  <= w_sel_wdata;
                  r_funct3 <= w_sel_funct3;
                  if (!w_sel_we) begin
                     r_owner <= w_winner;
                     r_lat   <= LAT_W'(READ_LATENCY - 1);
                     r_state <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (r_lat != '0) begin
                  r_lat <= r_lat - LAT_W'(1);
               end else begin
                  r_state <= IDLE;
                  if (r_owner == OWN_CORE) r_core_rdata <= mem_rdata;
                  else                     r_dbg_rdata  <= mem_rdata;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at read latency 1 and 3
module tb_mem_port_arbiter;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      logic        we;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;
   ev_t q1[$];
   ev_t q3[$];

   logic        reset, sel3, dbg_lock;
   logic        core_req, core_we, dbg_req, dbg_we;
   logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
   logic [2:0]  core_funct3, dbg_funct3;

   logic w_creq1, w_dreq1, w_creq3, w_dreq3;
   assign w_creq1 = core_req & ~sel3;
   assign w_dreq1 = dbg_req  & ~sel3;
   assign w_creq3 = core_req &  sel3;
   assign w_dreq3 = dbg_req  &  sel3;

   logic        core_gnt1, core_rvalid1, dbg_gnt1, dbg_rvalid1, mem_we1, busy1;
   logic [31:0] core_rdata1, dbg_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic [2:0]  mem_funct3_1;
   logic        core_gnt3, core_rvalid3, dbg_gnt3, dbg_rvalid3, mem_we3, busy3;
   logic [31:0] core_rdata3, dbg_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
   logic [2:0]  mem_funct3_3;

   mem_port_arbiter #(.READ_LATENCY(1), .AW(32)) u_dut1 (
      .clk(clk), .reset(reset),
      .core_req(w_creq1), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_funct3(core_funct3), .core_gnt(core_gnt1), .core_rvalid(core_rvalid1), .core_rdata(core_rdata1),
      .dbg_req(w_dreq1), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_funct3(dbg_funct3), .dbg_gnt(dbg_gnt1), .dbg_rvalid(dbg_rvalid1), .dbg_rdata(dbg_rdata1),
      .dbg_lock(dbg_lock), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_funct3(mem_funct3_1), .mem_rdata(mem_rdata1), .busy(busy1)
   );

   mem_port_arbiter #(.READ_LATENCY(3), .AW(32)) u_dut3 (
      .clk(clk), .reset(reset),
      .core_req(w_creq3), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_funct3(core_funct3), .core_gnt(core_gnt3), .core_rvalid(core_rvalid3), .core_rdata(core_rdata3),
      .dbg_req(w_dreq3), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_funct3(dbg_funct3), .dbg_gnt(dbg_gnt3), .dbg_rvalid(dbg_rvalid3), .dbg_rdata(dbg_rdata3),
      .dbg_lock(dbg_lock), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
      .mem_funct3(mem_funct3_3), .mem_rdata(mem_rdata3), .busy(busy3)
   );

   // Synchronous-read memory model: word index = addr[7:2], data appears LAT cycles after the address
   logic [31:0] mem [0:63];
   logic [5:0]  a1;
   logic [5:0]  a3 [0:2];
   always @(posedge clk) begin
      if (!reset) begin
         mem[4] <= 32'hDEADBEEF;
         mem[8] <= 32'hCAFEF00D;
      end else begin
         if (mem_we1) mem[mem_addr1[7:2]] <= mem_wdata1;
         if (mem_we3) mem[mem_addr3[7:2]] <= mem_wdata3;
      end
      a1    <= mem_addr1[7:2];
      a3[0] <= mem_addr3[7:2];
      a3[1] <= a3[0];
      a3[2] <= a3[1];
   end
   assign mem_rdata1 = mem[a1];
   assign mem_rdata3 = mem[a3[2]];

   task automatic push(input int d, input int kind, input int off, input logic [31:0] val, input logic we);
      ev_t e;
      e.cyc  = cyc + off;
      e.kind = kind;
      e.val  = val;
      e.we   = we;
      if (d == 1) q1.push_back(e);
      else        q3.push_back(e);
   endtask

   // kind: 0 core grant, 1 dbg grant, 2 core rvalid, 3 dbg rvalid
   task automatic sb(input int d, input int kind, input logic [31:0] val, input logic we);
      ev_t e;
      int  sz;
      n_cmp++;
      sz = (d == 1) ? q1.size() : q3.size();
      if (sz == 0) begin
         n_err++;
         $display("FAIL sb_dut%0d unexpected kind=%0d cyc=%0d val=%h", d, kind, cyc, val);
      end else begin
         if (d == 1) e = q1.pop_front();
         else        e = q3.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.val !== val || e.we !== we) begin
            n_err++;
            $display("FAIL sb_dut%0d got kind=%0d cyc=%0d val=%h we=%b want kind=%0d cyc=%0d val=%h we=%b",
                     d, kind, cyc, val, we, e.kind, e.cyc, e.val, e.we);
         end
      end
   endtask

   always @(negedge clk) begin
      if (core_gnt1)    sb(1, 0, mem_addr1, mem_we1);
      if (dbg_gnt1)     sb(1, 1, mem_addr1, mem_we1);
      if (core_rvalid1) sb(1, 2, core_rdata1, 1'b0);
      if (dbg_rvalid1)  sb(1, 3, dbg_rdata1, 1'b0);
      if (core_gnt3)    sb(3, 0, mem_addr3, mem_we3);
      if (dbg_gnt3)     sb(3, 1, mem_addr3, mem_we3);
      if (core_rvalid3) sb(3, 2, core_rdata3, 1'b0);
      if (dbg_rvalid3)  sb(3, 3, dbg_rdata3, 1'b0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; sel3 = 1'b0; dbg_lock = 1'b0;
      core_req = 1'b1; core_we = 1'b1; core_addr = 32'h40; core_wdata = 32'hC000_0000; core_funct3 = 3'b010;
      dbg_req  = 1'b1; dbg_we  = 1'b1; dbg_addr  = 32'h80; dbg_wdata  = 32'hD000_0000; dbg_funct3  = 3'b010;
      tick(); tick(); tick();

      chk("rst_core_gnt", {31'd0, core_gnt1}, 32'd0);
      chk("rst_dbg_gnt", {31'd0, dbg_gnt1}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we1}, 32'd0);
      chk("rst_mem_addr", mem_addr1, 32'd0);
      chk("rst_core_rdata", core_rdata1, 32'd0);
      chk("rst_busy3", {31'd0, busy3}, 32'd0);

      // Back-to-back contended writes right out of reset: core, dbg, core, dbg
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         core_addr  = 32'h40 + 32'(4 * i);
         core_wdata = 32'hC000_0000 + 32'(i);
         dbg_addr   = 32'h80 + 32'(4 * i);
         dbg_wdata  = 32'hD000_0000 + 32'(i);
         if (i % 2 == 0) push(1, 0, 0, core_addr, 1'b1);
         else            push(1, 1, 0, dbg_addr, 1'b1);
         tick();
      end
      core_req = 1'b0; dbg_req = 1'b0; core_we = 1'b0; dbg_we = 1'b0;
      tick();

      // Core-only read of 0x10
      core_req = 1'b1; core_addr = 32'h10;
      push(1, 0, 0, 32'h10, 1'b0);
      push(1, 2, 1, 32'hDEADBEEF, 1'b0);
      tick();
      core_req = 1'b0;
      tick(); tick();

      // Lock held: only dbg granted; it reads back core's write at 0x48
      dbg_lock = 1'b1;
      core_req = 1'b1; core_addr = 32'h20;
      dbg_req  = 1'b1; dbg_addr  = 32'h48;
      push(1, 1, 0, 32'h48, 1'b0);
      push(1, 3, 1, 32'hC000_0002, 1'b0);
      tick();
      dbg_req = 1'b0;
      tick();
      tick();
      dbg_lock = 1'b0;
      push(1, 0, 0, 32'h20, 1'b0);
      push(1, 2, 1, 32'hCAFEF00D, 1'b0);
      tick();
      core_req = 1'b0;
      tick(); tick();

      // Lock rising during an in-flight core read
      core_req = 1'b1; core_addr = 32'h10;
      push(1, 0, 0, 32'h10, 1'b0);
      push(1, 2, 1, 32'hDEADBEEF, 1'b0);
      tick();
      core_req = 1'b0; dbg_lock = 1'b1;
      tick();
      dbg_lock = 1'b0;
      tick();

      // Reset in the middle of a core read
      core_req = 1'b1; core_addr = 32'h20;
      push(1, 0, 0, 32'h20, 1'b0);
      tick();
      reset = 1'b0;
      #1;
      chk("mid_rst_core_gnt", {31'd0, core_gnt1}, 32'd0);
      chk("mid_rst_core_rdata", core_rdata1, 32'd0);
      chk("mid_rst_dbg_rdata", dbg_rdata1, 32'd0);
      chk("mid_rst_mem_addr", mem_addr1, 32'd0);
      chk("mid_rst_mem_wdata", mem_wdata1, 32'd0);
      chk("mid_rst_mem_funct3", {29'd0, mem_funct3_1}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy1}, 32'd0);
      tick(); tick();
      reset = 1'b1;
      core_addr = 32'h10;
      dbg_req = 1'b1; dbg_addr = 32'h20;
      push(1, 0, 0, 32'h10, 1'b0);
      push(1, 2, 1, 32'hDEADBEEF, 1'b0);
      push(1, 1, 2, 32'h20, 1'b0);
      push(1, 3, 3, 32'hCAFEF00D, 1'b0);
      tick();
      core_req = 1'b0;
      tick(); tick();
      dbg_req = 1'b0;
      tick(); tick();
      chk("hold_core_rdata", core_rdata1, 32'hDEADBEEF);
      chk("hold_dbg_rdata", dbg_rdata1, 32'hCAFEF00D);

      // Read latency 3: dbg read, core waits until the port frees up
      sel3 = 1'b1;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10; dbg_funct3 = 3'b100;
      push(3, 1, 0, 32'h10, 1'b0);
      push(3, 3, 3, 32'hDEADBEEF, 1'b0);
      tick();
      dbg_req = 1'b0; dbg_addr = 32'h0; dbg_funct3 = 3'b000;
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h20;
      push(3, 0, 3, 32'h20, 1'b0);
      push(3, 2, 6, 32'hCAFEF00D, 1'b0);
      chk("l3_busy_n1", {31'd0, busy3}, 32'd1);
      tick();
      chk("l3_busy_n2", {31'd0, busy3}, 32'd1);
      chk("l3_held_addr", mem_addr3, 32'h10);
      chk("l3_held_funct3", {29'd0, mem_funct3_3}, 32'd4);
      tick();
      chk("l3_busy_n3", {31'd0, busy3}, 32'd1);
      tick();
      chk("l3_busy_n4", {31'd0, busy3}, 32'd0);
      tick();
      core_req = 1'b0;
      chk("l3_busy_n5", {31'd0, busy3}, 32'd1);
      tick(); tick(); tick(); tick();

      chk("q1_drained", q1.size(), 32'd0);
      chk("q3_drained", q3.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
